// File: rtl/grid_frame_builder_pkg.sv
// Shared grid geometry, controller state encoding and cell indexing for the
// frame builder and the grid storage controller.
package grid_frame_builder_pkg;

  localparam int GRID_W     = 8;
  localparam int GRID_H     = 18;
  localparam int FRAME_BITS = GRID_W * GRID_H;

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    SCAN,
    SHIFT
  } state_t;

  // Cell (x,y) lives at bit x + GRID_W*y; the largest index (143) fits in 8 bits.
  function automatic logic [7:0] idx(input logic [7:0] x, input logic [7:0] y);
    return x + 8'(GRID_W) * y;
  endfunction

endpackage

// File: rtl/grid_frame_builder_if.sv
// Piece/lock inputs and composed-frame outputs between the game logic and the
// frame builder.
interface grid_frame_builder_if;
  import grid_frame_builder_pkg::*;

  logic                  piece_valid;
  logic [15:0]           piece_cells;
  logic [7:0]            piece_x;
  logic [7:0]            piece_y;
  logic                  lock_req;
  logic                  draw_finish;
  logic [FRAME_BITS-1:0] data_swap;
  logic                  busy;
  logic                  lock_ack;
  logic [2:0]            lines_last;
  logic [15:0]           lines_total;

  modport master (
    output piece_valid, piece_cells, piece_x, piece_y, lock_req, draw_finish,
    input  data_swap, busy, lock_ack, lines_last, lines_total
  );

  modport slave (
    input  piece_valid, piece_cells, piece_x, piece_y, lock_req, draw_finish,
    output data_swap, busy, lock_ack, lines_last, lines_total
  );

endinterface

// File: rtl/grid_frame_builder_piece_overlay.sv
// Places the 4x4 piece mask onto the full frame; cells falling outside the
// grid are dropped.
module piece_overlay
  import grid_frame_builder_pkg::*;
(
  input  logic                  piece_valid,
  input  logic [15:0]           piece_cells,
  input  logic [7:0]            piece_x,
  input  logic [7:0]            piece_y,
  output logic [FRAME_BITS-1:0] overlay
);

  // One extra bit so that piece_x/piece_y near 255 cannot wrap back onto the grid.
  logic [8:0] cx;
  logic [8:0] cy;

  always_comb begin
    overlay = '0;
    cx      = '0;
    cy      = '0;
    if (piece_valid) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          cx = {1'b0, piece_x} + 9'(j);
          cy = {1'b0, piece_y} + 9'(i);
          if (piece_cells[4'(4 * i + j)] && (cx < 9'(GRID_W)) && (cy < 9'(GRID_H)))
            overlay[idx(cx[7:0], cy[7:0])] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/grid_frame_builder.sv
// Owns the locked playfield, composes playfield|piece into data_swap while idle,
// and on lock merges the piece and collapses full rows bottom-up.
//
// state | meaning
// IDLE  | compose frame every cycle, wait for lock_req
// MERGE | OR piece into playfield, point at bottom row
// SCAN  | test current row; full -> SHIFT, else move up or finish
// SHIFT | drop everything above the current row by one, count the line
module grid_frame_builder
  import grid_frame_builder_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  grid_frame_builder_if.slave        gif
);

  state_t state, state_next;

  logic [FRAME_BITS-1:0] playfield;
  logic [FRAME_BITS-1:0] overlay;
  logic [FRAME_BITS-1:0] shifted;
  logic [FRAME_BITS-1:0] frame;
  logic [4:0]            row_ptr;
  logic [2:0]            lines_last;
  logic [15:0]           lines_total;
  logic                  lock_ack;

  logic [7:0] row_base;
  logic       row_full;
  logic       do_compose;
  logic       do_merge;
  logic       do_shift;
  logic       row_dec;
  logic       ack_set;

  piece_overlay u_piece_overlay (
    .piece_valid (gif.piece_valid),
    .piece_cells (gif.piece_cells),
    .piece_x     (gif.piece_x),
    .piece_y     (gif.piece_y),
    .overlay     (overlay)
  );

  assign row_base = {row_ptr, 3'b000};
  assign row_full = &playfield[row_base +: GRID_W];

  // Rows 1..row_ptr take the row above them; row 0 always empties.
  always_comb begin
    shifted = playfield;
    for (int k = 1; k < GRID_H; k++) begin
      if (5'(k) <= row_ptr)
        shifted[8'(k * GRID_W) +: GRID_W] = playfield[8'((k - 1) * GRID_W) +: GRID_W];
    end
    shifted[GRID_W-1:0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_compose = 1'b0;
    do_merge   = 1'b0;
    do_shift   = 1'b0;
    row_dec    = 1'b0;
    ack_set    = 1'b0;
    case (state)
      IDLE: begin
        do_compose = 1'b1;
        if (gif.lock_req) state_next = MERGE;
      end
      MERGE: begin
        do_merge   = 1'b1;
        state_next = SCAN;
      end
      SCAN: begin
        if (row_full) begin
          state_next = SHIFT;
        end else if (row_ptr != 5'd0) begin
          row_dec = 1'b1;
        end else begin
          ack_set    = 1'b1;
          state_next = IDLE;
        end
      end
      SHIFT: begin
        do_shift   = 1'b1;
        state_next = SCAN;
      end
      default: state_next = IDLE;
    endcase
  end

  // The frame register only loads in IDLE, so a collapse in progress is never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      playfield   <= '0;
      frame       <= '0;
      row_ptr     <= '0;
      lines_last  <= '0;
      lines_total <= '0;
      lock_ack    <= 1'b0;
    end else begin
      lock_ack <= ack_set;
      if (do_compose) frame <= playfield | overlay;
      if (do_merge) begin
        playfield  <= playfield | overlay;
        row_ptr    <= 5'(GRID_H - 1);
        lines_last <= '0;
      end
      if (row_dec) row_ptr <= row_ptr - 5'd1;
      if (do_shift) begin
        playfield   <= shifted;
        lines_last  <= lines_last + 3'd1;
        lines_total <= lines_total + 16'd1;
      end
    end
  end

  assign gif.data_swap   = frame;
  assign gif.busy        = (state != IDLE);
  assign gif.lock_ack    = lock_ack;
  assign gif.lines_last  = lines_last;
  assign gif.lines_total = lines_total;

endmodule

// File: tb/tb_grid_frame_builder.sv
// Directed bench: stimulus queues expected acks and swap frames, a monitor
// compares them when the DUT acks or the bench strobes draw_finish.
module tb_grid_frame_builder;
  import grid_frame_builder_pkg::*;

  typedef struct {
    int          cyc;
    logic [2:0]  last;
    logic [15:0] total;
  } ack_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;

  ack_t                  ack_q[$];
  logic [FRAME_BITS-1:0] frame_q[$];

  grid_frame_builder_if gif();

  grid_frame_builder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gif   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [FRAME_BITS-1:0] row(input int r, input logic [7:0] v);
    logic [FRAME_BITS-1:0] t;
    t = '0;
    t[8*r +: 8] = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [FRAME_BITS-1:0] act,
                       input logic [FRAME_BITS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_piece(input logic v, input logic [15:0] cells,
                           input logic [7:0] x, input logic [7:0] y);
    gif.piece_valid = v;
    gif.piece_cells = cells;
    gif.piece_x     = x;
    gif.piece_y     = y;
  endtask

  task automatic swap(input logic [FRAME_BITS-1:0] exp);
    frame_q.push_back(exp);
    gif.draw_finish = 1'b1;
    step(1);
    gif.draw_finish = 1'b0;
  endtask

  task automatic lock(input int clears, input logic [2:0] last, input logic [15:0] total);
    ack_q.push_back('{cyc + 20 + 2 * clears, last, total});
    gif.lock_req = 1'b1;
    step(1);
    gif.lock_req = 1'b0;
  endtask

  // Monitor: plays the storage controller (draw_finish) and the lock consumer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gif.draw_finish) begin
        if (frame_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL swap_unexpected: no expected frame queued");
        end else begin
          check("swap_frame", gif.data_swap, frame_q.pop_front());
        end
      end
      if (gif.lock_ack) begin
        if (ack_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL ack_unexpected: ack at cycle %0d, none expected", cyc);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          check("ack_cycle", FRAME_BITS'(cyc), FRAME_BITS'(e.cyc));
          check("lines_last", FRAME_BITS'(gif.lines_last), FRAME_BITS'(e.last));
          check("lines_total", FRAME_BITS'(gif.lines_total), FRAME_BITS'(e.total));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_BITS-1:0] pre;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    gif.lock_req    = 1'b0;
    gif.draw_finish = 1'b0;
    set_piece(1'b0, 16'h0, 8'd0, 8'd0);
    step(2);
    check("rst_data_swap", gif.data_swap, '0);
    check("rst_busy", FRAME_BITS'(gif.busy), '0);
    check("rst_lock_ack", FRAME_BITS'(gif.lock_ack), '0);
    check("rst_lines_last", FRAME_BITS'(gif.lines_last), '0);
    check("rst_lines_total", FRAME_BITS'(gif.lines_total), '0);
    rst_n = 1'b1;
    step(3);
    swap('0);

    // O-piece overlay, with 1-cycle frame latency
    set_piece(1'b1, 16'h0033, 8'd3, 8'd0);
    swap('0);
    swap(FRAME_BITS'(144'h1818));

    // Clipped I-piece at the bottom-right corner
    set_piece(1'b1, 16'h000F, 8'd6, 8'd17);
    step(1);
    swap(row(17, 8'hC0));
    lock(0, 3'd0, 16'd0);
    step(3);
    check("busy_during_lock", FRAME_BITS'(gif.busy), FRAME_BITS'(1));
    step(25);
    set_piece(1'b0, 16'h0, 8'd0, 8'd0);
    step(2);
    swap(row(17, 8'hC0));

    // Preload row 17 cols 0..3 and a row-16 cell at column 2
    set_piece(1'b1, 16'h000F, 8'd0, 8'd17);
    step(1);
    lock(0, 3'd0, 16'd0);
    step(22);
    set_piece(1'b1, 16'h0001, 8'd2, 8'd16);
    step(1);
    lock(0, 3'd0, 16'd0);
    step(22);

    // Single clear; swap in the lock cycle sees the pre-lock frame
    set_piece(1'b1, 16'h000F, 8'd4, 8'd17);
    step(1);
    pre = row(17, 8'hFF) | row(16, 8'h04);
    frame_q.push_back(pre);
    ack_q.push_back('{cyc + 22, 3'd1, 16'd1});
    gif.draw_finish = 1'b1;
    gif.lock_req    = 1'b1;
    step(1);
    gif.draw_finish = 1'b0;
    gif.lock_req    = 1'b0;
    step(1);
    // lock_req while busy, with a different piece: must neither merge nor ack
    set_piece(1'b1, 16'h0001, 8'd0, 8'd0);
    gif.lock_req = 1'b1;
    step(1);
    gif.lock_req = 1'b0;
    swap(pre);
    step(30);
    check("idle_after_lock", FRAME_BITS'(gif.busy), '0);
    set_piece(1'b0, 16'h0, 8'd0, 8'd0);
    step(2);
    swap(row(17, 8'h04));

    // Double clear setup: row 17 = F4, row 16 = F0, row 15 = 10
    set_piece(1'b1, 16'h000F, 8'd4, 8'd17);
    step(1);
    lock(0, 3'd0, 16'd1);
    step(22);
    set_piece(1'b1, 16'h00F1, 8'd4, 8'd15);
    step(1);
    lock(0, 3'd0, 16'd1);
    step(22);
    set_piece(1'b1, 16'h00BF, 8'd0, 8'd16);
    step(1);
    pre = row(15, 8'h10) | row(16, 8'hFF) | row(17, 8'hFF);
    lock(2, 3'd2, 16'd3);
    step(3);
    swap(pre);
    step(5);
    swap(pre);
    step(20);
    set_piece(1'b0, 16'h0, 8'd0, 8'd0);
    step(2);
    swap(row(17, 8'h10));

    // Lock with no piece: scan still runs and acks
    lock(0, 3'd0, 16'd3);
    step(22);
    swap(row(17, 8'h10));

    // Reset in the middle of a scan: no ack, everything back to zero
    gif.lock_req = 1'b1;
    step(1);
    gif.lock_req = 1'b0;
    step(6);
    check("busy_mid_scan", FRAME_BITS'(gif.busy), FRAME_BITS'(1));
    rst_n = 1'b0;
    step(1);
    check("midrst_busy", FRAME_BITS'(gif.busy), '0);
    check("midrst_lines_total", FRAME_BITS'(gif.lines_total), '0);
    check("midrst_data_swap", gif.data_swap, '0);
    rst_n = 1'b1;
    step(40);
    swap('0);

    check("acks_outstanding", FRAME_BITS'(ack_q.size()), '0);
    check("frames_outstanding", FRAME_BITS'(frame_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grid_frame_builder.md
Name: grid_frame_builder

Overview:
- Producer side of the double-buffered Tetris grid. Owns the locked-cell playfield (8x18), overlays the falling piece, and presents the composed 144-bit frame on data_swap.
- The grid storage controller copies data_swap into its display buffer on draw_finish.
- On a lock request, merges the piece into the playfield, clears full rows with a sequential scan/shift engine, then acknowledges.

Parameters:
- GRID_W, 8, columns per row (bit width of one row)
- GRID_H, 18, rows; frame width = GRID_W*GRID_H = 144

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- piece_valid  in  1  falling piece present; include it in the overlay
- piece_cells  in  16  4x4 piece mask; bit 4*i+j = piece row i, column j
- piece_x  in  8  grid column of the mask's top-left cell
- piece_y  in  8  grid row of the mask's top-left cell
- lock_req  in  1  single-cycle pulse: merge the current piece into the playfield
- draw_finish  in  1  frame-end strobe (storage swap); samples data_swap
- data_swap  out  144  composed frame: playfield OR piece overlay
- busy  out  1  lock/clear engine active
- lock_ack  out  1  single-cycle pulse: lock and row clearing complete
- lines_last  out  3  rows cleared by the last lock (0..4)
- lines_total  out  16  total rows cleared since reset; wraps at 65535->0

Behaviour:
- Layout: row r occupies bits [8r+7:8r]; cell (x,y) is bit x+8y; row 0 is top, row 17 is bottom.
- Piece mapping: mask bit (i,j) maps to cell (piece_x+j, piece_y+i).
- Clipping: cells with x>=8 or y>=18 are dropped silently. No collision checking is done here.
- Reset (async, rst_n=0): playfield=0, data_swap=0, busy=0, lock_ack=0, lines_last=0, lines_total=0, state=IDLE.
- FSM states: IDLE, MERGE, SCAN, SHIFT. A 5-bit row pointer holds the current row.
- IDLE:
  - Each clk, data_swap <= playfield | overlay (overlay is 0 when piece_valid=0). Frame latency is 1 cycle.
  - lock_req=1 -> MERGE.
- MERGE: playfield |= overlay; row pointer=17; -> SCAN. busy=1 from MERGE through the last SCAN/SHIFT.
- SCAN at row r:
  - Row r all ones -> SHIFT.
  - Otherwise, r>0 -> r-1.
  - Otherwise (r=0) -> IDLE and assert lock_ack for 1 cycle.
- SHIFT:
  - Rows r..1 take the contents of rows r-1..0; row 0 is zeroed.
  - lines_last increments; lines_total increments.
  - Return to SCAN at the same r (rows above have dropped into r).
- lines_last is cleared when MERGE is entered.
- Timing: with lock_req sampled at edge T and no full rows, lock_ack is high in the cycle after edge T+19. Each cleared row adds 2 cycles.
- data_swap holds its last IDLE value while busy=1, so the display never shows a half-collapsed field.
- Boundaries:
  - lock_req while busy is ignored: no second ack, no merge.
  - lock_req and draw_finish in the same IDLE cycle: the swap receives the pre-lock frame; the lock proceeds normally.
  - piece_valid=0 at lock: the merge adds nothing and the scan still runs, then ack.
  - rst_n asserted mid-scan: immediate return to reset values; the partial clear is discarded.
  - draw_finish has no effect on this block's state. It is an input only, so integration can check that frames are stable at swap.

Decomposition:
- Shared package: GRID_W, GRID_H, FRAME_BITS, the state enum (IDLE/MERGE/SCAN/SHIFT), and a cell-index function idx(x,y)=x+GRID_W*y. The storage controller reuses the same package.
- One sub-module, piece_overlay: combinational mask -> 144-bit placement with clipping, used by both IDLE compose and MERGE.

Test Plan:
- Reset, then idle with piece_valid=0 -> data_swap=0, busy=0, lines_total=0.
- Overlay: O-piece mask 16'h0033 at (3,0) -> data_swap bits 3,4,11,12 set one cycle later, all others 0.
- Clipping: I-piece mask 16'h000F at x=6,y=17, then lock -> only bits 142,143 set after ack; lines_last=0; ack 20 cycles after the lock_req edge.
- Single clear: preload row 17 with cells 0..3 plus a row-16 cell via earlier locks. Lock I-piece 16'h000F at (4,17) -> row 17 cleared, former row 16 cell moves to row 17, lines_last=1, ack at +22.
- Double clear: two full bottom rows created by a lock -> lines_last=2, lines_total +2, data_swap unchanged until ack.
- lock_req pulsed while busy, and rst_n asserted mid-SCAN -> no extra ack; after reset the playfield is 0 and no ack pulse follows.
